fifo_arbiter: RTL
=================

FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 SHALL have parameter DW, default 10, the data width of every FIFO word.
REQ-002 SHALL have parameter N, default 4, the number of source FIFOs (fixed at 4 for this revision).
REQ-003 SHALL have clk  input  1  the single clock; all flops rise on posedge clk.
REQ-004 SHALL have reset_L  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have init  input  1  configuration request; 1 means hold in INIT and load thresholds.
REQ-006 SHALL have umbral_superior_in / umbral_inferior_in  input  3 each  almost-full / almost-empty thresholds to load.
REQ-007 SHALL have umbral_superior / umbral_inferior  output  3 each  registered thresholds broadcast to all FIFOs.
REQ-008 SHALL have empty_i  input  4  per-source FIFO empty flags, registered in the source.
REQ-009 SHALL have data_in0..data_in3  input  DW each  source FIFO read data, valid the cycle after that FIFO's pop.
REQ-010 SHALL have almost_full_down  input  1  almost-full flag from the downstream FIFO.
REQ-011 SHALL have pop_o  output  4  one-hot-or-zero pop strobes to the sources.
REQ-012 SHALL have push_o / data_out  output  1 / DW  push strobe and word to the downstream FIFO.
REQ-013 SHALL have idle_out / active_out  output  1 each  FSM status flags.

Function
REQ-014 SHALL implement FSM states RESET, INIT, IDLE and ACTIVE, with one state register.
REQ-015 SHALL leave RESET for INIT on the first clock edge after reset_L rises.
REQ-016 SHALL, in INIT, load umbral_*_in into umbral_* on every cycle, and SHALL move to IDLE when init=0.
REQ-017 SHALL move to INIT from IDLE or ACTIVE whenever init=1, and any pops in flight SHALL still complete their push.
REQ-018 SHALL move IDLE->ACTIVE when a grant is issued, and ACTIVE->IDLE in any cycle with no grant and no word in flight.
REQ-019 SHALL define a source as eligible when empty_i[k]=0; a grant SHALL occur only in IDLE or ACTIVE with almost_full_down=0 and at least one eligible source.
REQ-020 SHALL issue at most one grant per cycle, choosing the first eligible source searching from pointer rr_ptr (2 bits) upward modulo 4.
REQ-021 SHALL drive pop_o combinationally as the one-hot grant of the current cycle, and SHALL drive pop_o=0 when no grant occurs.
REQ-022 SHALL set rr_ptr to (granted index + 1) mod 4 on each grant, with wrap-around 3->0, and SHALL hold rr_ptr otherwise.
REQ-023 SHALL register the grant valid and index at cycle t, capture data_in of that index at the edge ending t+1, and assert push_o with that data_out in cycle t+2; latency pop to push is exactly 2 cycles.
REQ-024 SHALL support back-to-back grants, one word per cycle sustained, with push order equal to grant order.
REQ-025 SHALL stop new grants in the cycle almost_full_down=1, while up to 2 in-flight words still push; downstream almost-full threshold headroom covers these.
REQ-026 SHALL hold data_out at its last value when push_o=0.
REQ-027 SHALL drive idle_out=1 only in IDLE and active_out=1 only in ACTIVE.

Reset
REQ-028 SHALL, while reset_L=0 and independently of clk, set state=RESET, rr_ptr=0, the pipeline valids to 0, push_o=0, data_out=0, umbral_superior=0 and umbral_inferior=0.
REQ-029 SHALL, while reset_L=0, force pop_o=0 combinationally.
REQ-030 SHALL, on reset asserted mid-transfer, discard in-flight words with no push after reset release.

Structure
REQ-031 SHALL place DW, N, the FSM state encoding (2 bits) and the threshold width (3) in the shared transaction-layer package.
REQ-032 SHALL use one sub-module, rr_arbiter, the combinational round-robin grant taking eligible[3:0] and rr_ptr and returning a one-hot grant and an index.

Verification
REQ-033 SHALL cover reset then init=1 for 2 cycles with thresholds 3'b110 / 3'b001: umbral_* = 110/001, FSM in INIT, then IDLE after init=0, pop_o=0 throughout.
REQ-034 SHALL cover only source 2 non-empty with data_in2=10'd5: pop_o=4'b0100 in cycle t, push_o=1 with data_out=5 in cycle t+2.
REQ-035 SHALL cover all four sources non-empty continuously from rr_ptr=0: grant sequence 0,1,2,3,0 and push every cycle from t+2 onward.
REQ-036 SHALL cover almost_full_down rising after 3 grants: no pop from that cycle, exactly 2 further pushes, resume on the cycle it falls.
REQ-037 SHALL cover sources 1 and 3 eligible with rr_ptr=2: grant 3, then 1 (wrap-around), rr_ptr=2.
REQ-038 SHALL cover reset_L dropping with two words in flight: push_o=0 immediately and no push after release.

Source files
------------

// File: rtl/fifo_arbiter_pkg.sv
// ============================================================================
// fifo_arbiter_pkg : shared widths and FSM encoding for the FIFO arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package fifo_arbiter_pkg;
  localparam int DW_DEF = 10;
  localparam int N_DEF  = 4;
  localparam int TH_W   = 3;
  localparam int ST_W   = 2;

  localparam logic [ST_W-1:0] ST_RESET  = 2'd0;
  localparam logic [ST_W-1:0] ST_INIT   = 2'd1;
  localparam logic [ST_W-1:0] ST_IDLE   = 2'd2;
  localparam logic [ST_W-1:0] ST_ACTIVE = 2'd3;
endpackage

`default_nettype wire

// File: rtl/fifo_arbiter_rr.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick of the first eligible source
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_arbiter (
  input  logic [3:0] eligible,
  input  logic [1:0] rr_ptr,
  output logic [3:0] grant,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] cand;

  always_comb begin
    grant = 4'b0000;
    idx   = rr_ptr;
    any   = 1'b0;
    cand  = rr_ptr;
    for (int i = 0; i < 4; i++) begin
      cand = rr_ptr + 2'(i);
      if (!any && eligible[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_arbiter.sv
// ============================================================================
// fifo_arbiter : round-robin drain of 4 source FIFOs into one downstream FIFO
// Revision 1.0
// ============================================================================
`default_nettype none

module fifo_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int N  = N_DEF
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            init,
  input  logic [TH_W-1:0] umbral_superior_in,
  input  logic [TH_W-1:0] umbral_inferior_in,
  output logic [TH_W-1:0] umbral_superior,
  output logic [TH_W-1:0] umbral_inferior,
  input  logic [N-1:0]    empty_i,
  input  logic [DW-1:0]   data_in0,
  input  logic [DW-1:0]   data_in1,
  input  logic [DW-1:0]   data_in2,
  input  logic [DW-1:0]   data_in3,
  input  logic            almost_full_down,
  output logic [N-1:0]    pop_o,
  output logic            push_o,
  output logic [DW-1:0]   data_out,
  output logic            idle_out,
  output logic            active_out
);

  logic [ST_W-1:0] state_q, state_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic            v1_q, v1_d;
  logic [1:0]      idx1_q, idx1_d;
  logic            push_q, push_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic [TH_W-1:0] us_q, us_d;
  logic [TH_W-1:0] ui_q, ui_d;

  logic [3:0]      arb_grant;
  logic [1:0]      arb_idx;
  logic            arb_any;
  logic            grant_ok;
  logic [DW-1:0]   sel_data;

  rr_arbiter u_rr (
    .eligible (~empty_i),
    .rr_ptr   (rr_ptr_q),
    .grant    (arb_grant),
    .idx      (arb_idx),
    .any      (arb_any)
  );

  assign grant_ok = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) &&
                    !almost_full_down && arb_any;

  // Gated by reset_L directly so pops are suppressed even before any clock edge.
  assign pop_o = (reset_L && grant_ok) ? arb_grant : '0;

  always_comb begin
    sel_data = data_in0;
    case (idx1_q)
      2'd0: sel_data = data_in0;
      2'd1: sel_data = data_in1;
      2'd2: sel_data = data_in2;
      2'd3: sel_data = data_in3;
      default: sel_data = data_in0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    us_d     = us_q;
    ui_d     = ui_q;
    rr_ptr_d = grant_ok ? arb_idx + 2'd1 : rr_ptr_q;
    v1_d     = grant_ok;
    idx1_d   = grant_ok ? arb_idx : idx1_q;
    push_d   = v1_q;
    dout_d   = v1_q ? sel_data : dout_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        us_d = umbral_superior_in;
        ui_d = umbral_inferior_in;
        if (!init) state_d = ST_IDLE;
      end
      ST_IDLE, ST_ACTIVE: begin
        // The pop/push pipeline keeps running across a return to INIT.
        if (init)
          state_d = ST_INIT;
        else if (grant_ok)
          state_d = ST_ACTIVE;
        else if (!v1_q && !push_q)
          state_d = ST_IDLE;
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= ST_RESET;
      rr_ptr_q <= 2'd0;
      v1_q     <= 1'b0;
      idx1_q   <= 2'd0;
      push_q   <= 1'b0;
      dout_q   <= '0;
      us_q     <= '0;
      ui_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      v1_q     <= v1_d;
      idx1_q   <= idx1_d;
      push_q   <= push_d;
      dout_q   <= dout_d;
      us_q     <= us_d;
      ui_q     <= ui_d;
    end
  end

  assign push_o          = push_q;
  assign data_out        = dout_q;
  assign umbral_superior = us_q;
  assign umbral_inferior = ui_q;
  assign idle_out        = (state_q == ST_IDLE);
  assign active_out      = (state_q == ST_ACTIVE);

endmodule

`default_nettype wire
